data_sel_n_pipe: RTL and testbench

- Parametrised N:1 data selector with a registered, elastic output stage: N words of WIDTH bits in, one selected word out per accepted transfer.
- Valid/ready on both sides with a 2-entry skid buffer, so full throughput with no combinational path from out_ready to in_ready.
- Used in the CPU datapath where a selected operand must cross a pipeline boundary, such as forwarding-mux and writeback-mux stages.

---
 rtl/data_sel_n_pipe.sv | 162 ++++++++++++++++
 tb/tb_data_sel_n_pipe.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_sel_n_pipe.sv
// ---------------------------------------------------------------------------
// data_sel_n_pipe
//
// N:1 data selector feeding a registered, elastic output stage. One word is
// picked out of the flattened in_data bus by sel at the moment a transfer is
// accepted. It is then held in a 2-entry skid buffer (main + skid) behind a
// valid/ready handshake. in_ready comes only from the occupancy register, so
// there is no combinational path from out_ready to in_ready. The block still
// sustains one word per cycle while out_ready stays high.
//
// Parameters
//   WIDTH  bits per data word
//   N      number of input words (must be >= 2)
//   SEL_W  select width, derived from N; do not override
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_data    N*WIDTH flattened inputs; word k = in_data[k*WIDTH +: WIDTH]
//   sel        index of the word to forward, sampled with in_data
//   in_valid   upstream offers in_data/sel this cycle
//   in_ready   block accepts this cycle (registered state only)
//   out_data   selected word at the head of the buffer
//   out_err    head transfer had sel >= N (its data is forced to zero)
//   out_valid  out_data/out_err hold a valid transfer
//   out_ready  downstream accepts this cycle
//
// Optional feature (macro DATASEL_PERF_CNT_EN)
//   xfer_cnt   [31:0] number of drain cycles, wraps modulo 2^32
//   err_cnt    [15:0] number of drains with out_err = 1, wraps modulo 2^16
// ---------------------------------------------------------------------------
module data_sel_n_pipe #(
  parameter int WIDTH = 64,
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]   sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_err,
  output logic               out_valid,
`ifdef DATASEL_PERF_CNT_EN
  output logic [31:0]        xfer_cnt,
  output logic [15:0]        err_cnt,
`endif
  input  logic               out_ready
);

  // The state encodes how many entries the buffer holds.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   main_data, skid_data;
  logic               main_err, skid_err;
  logic [WIDTH-1:0]   pick_data;
  logic               pick_err;
  logic               accept, drain;
  logic               load_main, load_skid, main_from_skid;

  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign out_data  = main_data;
  assign out_err   = main_err;

  // The selection is a compare loop rather than an indexed part-select. This
  // keeps an out-of-range sel (possible when N is not a power of two) from
  // ever indexing past the end of in_data.
  // NOTE: every signal driven from always_comb gets a default first, so no
  // path through the block leaves it unassigned and infers a latch.
  always_comb begin
    pick_data = '0;
    pick_err  = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (sel == SEL_W'(k)) begin
        pick_data = in_data[k*WIDTH +: WIDTH];
        pick_err  = 1'b0;
      end
    end
  end

  // Next-state and register-load decode.
  always_comb begin
    state_nxt      = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          load_main = 1'b1;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (accept && drain) begin
          load_main = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          state_nxt = FULL;
        end else if (drain) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (drain) begin
          load_main      = 1'b1;
          main_from_skid = 1'b1;
          state_nxt      = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // NOTE: sequential state is assigned with non-blocking (<=) only. Every
  // register then samples pre-edge values, whatever order the statements are in.
  // NOTE: the data registers are reset as well as the state. Reset output
  // is defined as zero, and a discarded entry must never leak out later.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      main_data <= '0;
      main_err  <= 1'b0;
      skid_data <= '0;
      skid_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load_main) begin
        main_data <= main_from_skid ? skid_data : pick_data;
        main_err  <= main_from_skid ? skid_err  : pick_err;
      end
      if (load_skid) begin
        skid_data <= pick_data;
        skid_err  <= pick_err;
      end
    end
  end

`ifdef DATASEL_PERF_CNT_EN
  // The counters track the drain seen this cycle, so they show it one edge later.
  always_ff @(posedge clk) begin
    if (reset) begin
      xfer_cnt <= '0;
      err_cnt  <= '0;
    end else if (drain) begin
      xfer_cnt <= xfer_cnt + 32'd1;
      if (main_err) err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_sel_n_pipe.sv
// ---------------------------------------------------------------------------
// tb_data_sel_n_pipe
//
// Directed bench for data_sel_n_pipe. dut uses N=4 with WIDTH=64 and covers
// the main paths. dut3 uses N=3, where sel=3 is an out-of-range select.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_data_sel_n_pipe;

  localparam int WIDTH = 64;

  localparam logic [63:0] W0 = 64'h1111111111111111;
  localparam logic [63:0] W1 = 64'h2222222222222222;
  localparam logic [63:0] W2 = 64'h3333333333333333;
  localparam logic [63:0] W3 = 64'h4444444444444444;

  logic clk = 1'b0;
  logic reset;

  // N = 4 instance
  logic [4*WIDTH-1:0] in_data;
  logic [1:0]         sel;
  logic               in_valid, in_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_err, out_valid, out_ready;

  // N = 3 instance
  logic [3*WIDTH-1:0] in_data3;
  logic [1:0]         sel3;
  logic               in_valid3, in_ready3;
  logic [WIDTH-1:0]   out_data3;
  logic               out_err3, out_valid3, out_ready3;

`ifdef DATASEL_PERF_CNT_EN
  logic [31:0] xfer_cnt, xfer_cnt3;
  logic [15:0] err_cnt, err_cnt3;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  data_sel_n_pipe #(.WIDTH(WIDTH), .N(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .out_valid (out_valid),
`ifdef DATASEL_PERF_CNT_EN
    .xfer_cnt  (xfer_cnt),
    .err_cnt   (err_cnt),
`endif
    .out_ready (out_ready)
  );

  data_sel_n_pipe #(.WIDTH(WIDTH), .N(3)) dut3 (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data3),
    .sel       (sel3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .out_data  (out_data3),
    .out_err   (out_err3),
    .out_valid (out_valid3),
`ifdef DATASEL_PERF_CNT_EN
    .xfer_cnt  (xfer_cnt3),
    .err_cnt   (err_cnt3),
`endif
    .out_ready (out_ready3)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [1:0] s);
    sel      = s;
    in_valid = 1'b1;
  endtask

  initial begin
    logic [63:0] words [4];
    words[0] = W0; words[1] = W1; words[2] = W2; words[3] = W3;

    in_data    = {W3, W2, W1, W0};
    in_data3   = {W2, W1, W0};
    sel        = '0;
    sel3       = '0;
    in_valid   = 1'b1;   // driven during reset, which must ignore it
    in_valid3  = 1'b0;
    out_ready  = 1'b1;
    out_ready3 = 1'b1;
    reset      = 1'b1;
    #1;

    // ---- reset state ----
    tick();
    tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  out_data,       64'd0);
    check("rst_out_err",   64'(out_err),   64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    reset    = 1'b0;
    in_valid = 1'b0;
    tick();
    check("idle_out_valid", 64'(out_valid), 64'd0);

    // ---- single transfer, sel = 2, latency 1 ----
    offer(2'd2);
    tick();
    in_valid = 1'b0;
    check("single_valid", 64'(out_valid), 64'd1);
    check("single_data",  out_data,       W2);
    check("single_err",   64'(out_err),   64'd0);
    tick();
    check("single_drained", 64'(out_valid), 64'd0);

    // ---- streaming sel = 0..3 with out_ready high ----
    for (int i = 0; i < 4; i++) begin
      check($sformatf("stream_in_ready_%0d", i), 64'(in_ready), 64'd1);
      offer(2'(i));
      tick();
      check($sformatf("stream_valid_%0d", i), 64'(out_valid), 64'd1);
      check($sformatf("stream_data_%0d", i),  out_data,       words[i]);
    end
    in_valid = 1'b0;
    tick();
    check("stream_drained", 64'(out_valid), 64'd0);

    // ---- backpressure fills the skid buffer ----
    out_ready = 1'b0;
    offer(2'd0);
    tick();
    check("bp_one_in_ready", 64'(in_ready), 64'd1);
    offer(2'd1);
    tick();
    in_valid = 1'b0;
    check("bp_full_in_ready", 64'(in_ready), 64'd0);
    check("bp_full_data",     out_data,      W0);
    offer(2'd3);          // offered while full: must not be taken
    tick();
    in_valid = 1'b0;
    check("bp_hold_data",     out_data,      W0);
    check("bp_hold_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;     // W0 drains on this edge
    tick();
    check("bp_second_data",  out_data,       W1);
    check("bp_second_valid", 64'(out_valid), 64'd1);
    check("bp_in_ready_back", 64'(in_ready), 64'd1);
    tick();
    check("bp_drained", 64'(out_valid), 64'd0);

    // ---- reset while full: nothing replays ----
    out_ready = 1'b0;
    offer(2'd2);
    tick();
    offer(2'd3);
    tick();
    in_valid = 1'b0;
    check("mid_full_in_ready", 64'(in_ready), 64'd0);
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    out_ready = 1'b1;
    check("mid_rst_valid",    64'(out_valid), 64'd0);
    check("mid_rst_data",     out_data,       64'd0);
    check("mid_rst_in_ready", 64'(in_ready),  64'd1);
    tick();
    tick();
    check("mid_no_replay", 64'(out_valid), 64'd0);

    // ---- N = 3: in-range then out-of-range select ----
    sel3      = 2'd1;
    in_valid3 = 1'b1;
    tick();
    sel3 = 2'd3;
    check("n3_in_range_data", out_data3,      W1);
    check("n3_in_range_err",  64'(out_err3),  64'd0);
    tick();
    in_valid3 = 1'b0;
    check("n3_oor_valid", 64'(out_valid3), 64'd1);
    check("n3_oor_data",  out_data3,       64'd0);
    check("n3_oor_err",   64'(out_err3),   64'd1);
    tick();
    check("n3_drained", 64'(out_valid3), 64'd0);
`ifdef DATASEL_PERF_CNT_EN
    check("n3_err_cnt",  64'(err_cnt3),  64'd1);
    check("n3_xfer_cnt", 64'(xfer_cnt3), 64'd2);

    // ---- counter wrap ----
    force dut.xfer_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.xfer_cnt;
    offer(2'd0);
    tick();
    in_valid = 1'b0;
    check("cnt_before_wrap", 64'(xfer_cnt), 64'hFFFF_FFFF);
    tick();
    check("cnt_wrapped", 64'(xfer_cnt), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
